masterslave_jk_counter: RTL and testbench
=========================================

MASTERSLAVE_JK_COUNTER -- requirements
Module: masterslave_jk_counter

Interface
REQ-001 Parameter WIDTH, default 4: number of JK storage cells and the counter width; legal range 1..32.
REQ-002 Parameter MOD, default 16: counter modulus; legal range 2..2^WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  clock enable; when 0, all state holds regardless of mode.
REQ-006 mode  input  3  operation select, decoded per REQ-011.
REQ-007 j  input  WIDTH  per-bit J inputs, used only in JK mode.
REQ-008 k  input  WIDTH  per-bit K inputs, used only in JK mode.
REQ-009 d  input  WIDTH  parallel load value.
REQ-010 Outputs:
- q  output  WIDTH  registered state.
- q_bar  output  WIDTH  bitwise complement of q, at all times.
- tc  output  1  combinational terminal-count flag.
- ovf  output  1  registered one-cycle wrap/limit pulse.

Function
REQ-011 Mode decode, applied on a rising edge with en=1:
- 000 HOLD.
- 001 UP: q <= q+1.
- 010 DOWN: q <= q-1.
- 011 LOAD: q <= d.
- 100 JK: per bit, jk=00 hold, 01 clear, 10 set, 11 toggle.
- 101 CLEAR: q <= 0.
- 110, 111 HOLD.
REQ-012 UP with q >= MOD-1 SHALL set q <= 0 (wrap) and pulse ovf=1 on the next cycle.
REQ-013 DOWN with q == 0 SHALL set q <= MOD-1 (wrap) and pulse ovf=1 on the next cycle.
REQ-014 DOWN with q > MOD-1 (reachable only via JK mode) SHALL decrement normally, with no ovf.
REQ-015 LOAD with d >= MOD SHALL clamp, q <= MOD-1.
REQ-016 JK mode SHALL write the per-bit result unmodified; it is not checked against MOD, and ovf=0.
REQ-017 tc SHALL be 1 when either condition holds, else 0:
- mode=UP and q >= MOD-1;
- mode=DOWN and q == 0.
REQ-018 tc is independent of en.
REQ-019 ovf SHALL be 0 in every cycle not following a wrap/limit event, including cycles with en=0.
REQ-020 Latency: q reflects the operation one clock after the sampling edge; no pipelining.
REQ-021 All arithmetic is modulo 2^WIDTH before the MOD rules are applied; intermediate results carry no extra bits.

Reset
REQ-022 rst=1 at a rising edge SHALL force q=0, q_bar all-ones and ovf=0.
REQ-023 rst takes priority over en and mode.
REQ-024 rst asserted mid-sequence SHALL discard any pending ovf pulse.
REQ-025 The first edge after rst deasserts SHALL operate normally from q=0.

Configuration
REQ-026 Macro MASTERSLAVE_JK_SATURATE_EN selects limit behaviour.
REQ-027 When MASTERSLAVE_JK_SATURATE_EN is defined:
- UP at q >= MOD-1 holds q at MOD-1.
- DOWN at q == 0 holds q at 0.
- ovf still pulses, one cycle after each blocked step.
REQ-028 When MASTERSLAVE_JK_SATURATE_EN is not defined, the wrap behaviour of REQ-012 and REQ-013 applies.
REQ-029 All other requirements apply unchanged in both builds.

Verification (WIDTH=4, MOD=10, macro undefined unless noted)
REQ-030 Reset, then UP, en=1, for 12 cycles -> q = 1..9, 0, 1, 2; tc=1 while q=9; ovf=1 exactly one cycle after q goes 9->0.
REQ-031 From q=0, DOWN -> q=9 with ovf pulse; en=0 for 3 cycles -> q holds at 9, ovf=0.
REQ-032 LOAD d=4'd13 -> q=9; LOAD d=4'd5 -> q=5, q_bar=4'b1010.
REQ-033 From q=4'b0101, JK with j=4'b1100, k=4'b0110 -> q=4'b1001. Then JK with j=k=4'b1111 -> q=4'b0110. Then UP from JK-set q=4'b1111 -> q=0 with ovf.
REQ-034 Assert rst in the same cycle as a 9->0 UP step -> q=0 and no ovf pulse on the following cycle.
REQ-035 With MASTERSLAVE_JK_SATURATE_EN defined: UP from q=8 for 3 cycles -> q = 9, 9, 9, with ovf pulses after the 2nd and 3rd edges; DOWN from q=0 -> q=0 with ovf pulse.

Source files
------------

// File: rtl/masterslave_jk_counter.sv
// Modulo-MOD counter built from per-bit JK storage cells: hold/up/down/load/JK/clear.
// Define MASTERSLAVE_JK_SATURATE_EN to make UP/DOWN stop at their limits instead of wrapping.
module masterslave_jk_counter #(
   parameter int unsigned     WIDTH = 4,
   parameter longint unsigned MOD   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic             tc,
   output logic             ovf
);

   localparam logic [2:0] M_HOLD  = 3'b000;
   localparam logic [2:0] M_UP    = 3'b001;
   localparam logic [2:0] M_DOWN  = 3'b010;
   localparam logic [2:0] M_LOAD  = 3'b011;
   localparam logic [2:0] M_JK    = 3'b100;
   localparam logic [2:0] M_CLEAR = 3'b101;

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 64'd1);
   localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

   // Results are packed as {limit_hit, next_q}.
   function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] cur);
      if (cur >= MAX_Q) begin
`ifdef MASTERSLAVE_JK_SATURATE_EN
         return {1'b1, MAX_Q};
`else
         return {1'b1, {WIDTH{1'b0}}};
`endif
      end
      return {1'b0, cur + ONE_Q};
   endfunction

   // Values above MAX_Q (only reachable through JK mode) just count down normally.
   function automatic logic [WIDTH:0] step_down(input logic [WIDTH-1:0] cur);
      if (cur == '0) begin
`ifdef MASTERSLAVE_JK_SATURATE_EN
         return {1'b1, {WIDTH{1'b0}}};
`else
         return {1'b1, MAX_Q};
`endif
      end
      return {1'b0, cur - ONE_Q};
   endfunction

   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
      return (val > MAX_Q) ? MAX_Q : val;
   endfunction

   logic [WIDTH-1:0] q_p0;
   logic             ovf_p0;
   logic [WIDTH:0]   up_res;
   logic [WIDTH:0]   dn_res;
   logic [WIDTH-1:0] q_p1;
   logic             ovf_p1;

   // Stage 0: next-state decode from current state and mode.
   always_comb begin
      q_p0   = q_p1;
      ovf_p0 = 1'b0;
      up_res = step_up(q_p1);
      dn_res = step_down(q_p1);
      case (mode)
         M_UP: begin
            q_p0   = up_res[WIDTH-1:0];
            ovf_p0 = up_res[WIDTH];
         end
         M_DOWN: begin
            q_p0   = dn_res[WIDTH-1:0];
            ovf_p0 = dn_res[WIDTH];
         end
         M_LOAD:  q_p0 = clamp_load(d);
         M_JK:    q_p0 = (j & ~q_p1) | (~k & q_p1);
         M_CLEAR: q_p0 = '0;
         M_HOLD:  q_p0 = q_p1;
         default: q_p0 = q_p1;
      endcase
   end

   // Stage 1: state register; ovf is a single-cycle pulse and never survives a gated edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_p1   <= '0;
         ovf_p1 <= 1'b0;
      end else if (en) begin
         q_p1   <= q_p0;
         ovf_p1 <= ovf_p0;
      end else begin
         ovf_p1 <= 1'b0;
      end
   end

   assign q     = q_p1;
   assign q_bar = ~q_p1;
   assign ovf   = ovf_p1;
   assign tc    = ((mode == M_UP) && (q_p1 >= MAX_Q)) || ((mode == M_DOWN) && (q_p1 == '0));

endmodule

// File: tb/tb_masterslave_jk_counter.sv
// Self-checking bench for masterslave_jk_counter (WIDTH=4, MOD=10); vector table plus scoreboard.
// Expected values follow MASTERSLAVE_JK_SATURATE_EN when it is defined for the build.
module tb_masterslave_jk_counter;

   localparam int W = 4;
   localparam logic [2:0] HLD = 3'd0, UP = 3'd1, DN = 3'd2, LD = 3'd3, JK = 3'd4, CLR = 3'd5;

   typedef struct {
      logic         rst;
      logic         en;
      logic [2:0]   mode;
      logic [W-1:0] j;
      logic [W-1:0] k;
      logic [W-1:0] d;
      logic         exp_tc;
      logic [W-1:0] exp_q;
      logic         exp_ovf;
   } vec_t;

   typedef struct {
      logic [W-1:0] q;
      logic         ovf;
      int           idx;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic [2:0]   mode = 3'd0;
   logic [W-1:0] j = '0, k = '0, d = '0;
   logic [W-1:0] q, q_bar;
   logic         tc, ovf;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ovf_cnt;

   always #5 clk = ~clk;

   masterslave_jk_counter #(.WIDTH(W), .MOD(10)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
      .q(q), .q_bar(q_bar), .tc(tc), .ovf(ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic add(input logic r, input logic e, input logic [2:0] m,
                      input logic [W-1:0] jj, input logic [W-1:0] kk, input logic [W-1:0] dd,
                      input logic t, input logic [W-1:0] eq, input logic eo);
      vec_t v;
      v.rst = r; v.en = e; v.mode = m; v.j = jj; v.k = kk; v.d = dd;
      v.exp_tc = t; v.exp_q = eq; v.exp_ovf = eo;
      vecs.push_back(v);
   endtask

   task automatic apply(input vec_t v, input int idx);
      exp_t         e;
      exp_t         got;
      logic [W-1:0] qb;
      @(negedge clk);
      rst = v.rst; en = v.en; mode = v.mode; j = v.j; k = v.k; d = v.d;
      #1;
      check($sformatf("v%0d tc", idx), 32'(tc), 32'(v.exp_tc));
      e.q = v.exp_q; e.ovf = v.exp_ovf; e.idx = idx;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      qb  = ~got.q;
      check($sformatf("v%0d q", got.idx), 32'(q), 32'(got.q));
      check($sformatf("v%0d q_bar", got.idx), 32'(q_bar), 32'(qb));
      check($sformatf("v%0d ovf", got.idx), 32'(ovf), 32'(got.ovf));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // rst en mode j k d | tc q ovf
      add(1, 1, HLD, 0, 0, 0, 0, 0, 0);
`ifdef MASTERSLAVE_JK_SATURATE_EN
      add(0, 1, LD,  0, 0, 8, 0, 8, 0);
      add(0, 1, UP,  0, 0, 0, 0, 9, 0);
      add(0, 1, UP,  0, 0, 0, 1, 9, 1);
      add(0, 1, UP,  0, 0, 0, 1, 9, 1);
      add(0, 1, HLD, 0, 0, 0, 0, 9, 0);
      add(0, 1, CLR, 0, 0, 0, 0, 0, 0);
      add(0, 1, DN,  0, 0, 0, 1, 0, 1);
      add(0, 1, DN,  0, 0, 0, 1, 0, 1);
      add(0, 1, JK,  4'hF, 0, 0, 0, 4'hF, 0);
      add(0, 1, UP,  0, 0, 0, 1, 9, 1);
      add(0, 1, DN,  0, 0, 0, 0, 8, 0);
      add(0, 1, LD,  0, 0, 14, 0, 9, 0);
      add(1, 1, UP,  0, 0, 0, 1, 0, 0);
      add(0, 1, HLD, 0, 0, 0, 0, 0, 0);
`else
      for (int i = 1; i <= 9; i++) add(0, 1, UP, 0, 0, 0, 0, W'(i), 0);
      add(0, 1, UP,  0, 0, 0, 1, 0, 1);
      add(0, 1, UP,  0, 0, 0, 0, 1, 0);
      add(0, 1, UP,  0, 0, 0, 0, 2, 0);
      add(0, 1, CLR, 0, 0, 0, 0, 0, 0);
      add(0, 1, DN,  0, 0, 0, 1, 9, 1);
      add(0, 0, UP,  0, 0, 0, 1, 9, 0);
      add(0, 0, DN,  0, 0, 0, 0, 9, 0);
      add(0, 0, LD,  0, 0, 0, 0, 9, 0);
      add(0, 1, LD,  0, 0, 13, 0, 9, 0);
      add(0, 1, LD,  0, 0, 5, 0, 5, 0);
      add(0, 1, DN,  0, 0, 0, 0, 4, 0);
      add(0, 1, LD,  0, 0, 5, 0, 5, 0);
      add(0, 1, JK,  4'b1100, 4'b0110, 0, 0, 4'b1001, 0);
      add(0, 1, JK,  4'b1111, 4'b1111, 0, 0, 4'b0110, 0);
      add(0, 1, JK,  4'b1111, 4'b0000, 0, 0, 4'b1111, 0);
      add(0, 1, UP,  0, 0, 0, 1, 0, 1);
      add(0, 1, JK,  4'b1111, 4'b0000, 0, 0, 4'b1111, 0);
      add(0, 1, DN,  0, 0, 0, 0, 14, 0);
      add(0, 1, DN,  0, 0, 0, 0, 13, 0);
      add(0, 1, LD,  0, 0, 10, 0, 9, 0);
      add(0, 1, LD,  0, 0, 0, 0, 0, 0);
      add(0, 1, LD,  0, 0, 9, 0, 9, 0);
      add(0, 1, 3'd6, 0, 0, 0, 0, 9, 0);
      add(0, 1, 3'd7, 0, 0, 0, 0, 9, 0);
      add(0, 1, HLD, 0, 0, 0, 0, 9, 0);
      add(1, 1, UP,  0, 0, 0, 1, 0, 0);
      add(0, 1, HLD, 0, 0, 0, 0, 0, 0);
      add(0, 1, UP,  0, 0, 0, 0, 1, 0);
      add(1, 0, UP,  0, 0, 0, 0, 0, 0);
      add(0, 1, LD,  0, 0, 9, 0, 9, 0);
      add(0, 1, UP,  0, 0, 0, 1, 0, 1);
      add(0, 0, UP,  0, 0, 0, 0, 0, 0);
`endif
      foreach (vecs[i]) apply(vecs[i], i);

      // Ten UP steps from reset: exactly one limit event, landing on 0 (wrap) or 9 (saturate).
      @(negedge clk);
      rst = 1'b1; en = 1'b1; mode = HLD;
      @(negedge clk);
      rst = 1'b0; mode = UP;
      ovf_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (ovf === 1'b1) ovf_cnt++;
      end
      check("run10 ovf_count", 32'(ovf_cnt), 32'd1);
`ifdef MASTERSLAVE_JK_SATURATE_EN
      check("run10 q", 32'(q), 32'd9);
`else
      check("run10 q", 32'(q), 32'd0);
`endif

      // Alternating enable: six edges with en toggling advance the count by three.
      @(negedge clk);
      mode = CLR; en = 1'b1;
      @(posedge clk);
      ovf_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         mode = UP;
         en = (i % 2 == 0);
         @(posedge clk);
         #1;
         if (ovf === 1'b1) ovf_cnt++;
      end
      check("gated q", 32'(q), 32'd3);
      check("gated ovf_count", 32'(ovf_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
